// File: rtl/iir_result_checker.sv
// Purpose : end-of-stream checker comparing the IIR filter output stream against a preloaded expected-sample memory.
// Latency : mismatch/err_cnt/first_err update on the edge that samples vin; done rises with the last sample's result.
// Backpress: none; samples are accepted at full rate whenever vin is high, samples arriving in DONE flag overflow.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   load_en/addr/data       expected-memory write port (ignored while a run is active)
//   start, n_exp            start a run over n_exp samples (clamped to 2**AW)
//   vin, din                filter output stream (vout/dout)
//   busy, done, pass        run status and verdict
//   mismatch                one-cycle pulse per failing sample
//   err_cnt, first_err      saturating failure count, index of the first failure
//   overflow, timeout       sticky status flags
// Optional feature macro: CHK_TIMEOUT_EN (idle-cycle watchdog in RUN; timeout tied 0 otherwise).
module iir_result_checker #(
  parameter int DW      = 9,
  parameter int AW      = 4,
  parameter int TOL     = 0,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  input  logic          start,
  input  logic [AW:0]   n_exp,
  input  logic          vin,
  input  logic [DW-1:0] din,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          mismatch,
  output logic [AW:0]   err_cnt,
  output logic [AW-1:0] first_err,
  output logic          overflow,
  output logic          timeout
);

  localparam int DEPTH = 1 << AW;
  localparam logic [DW:0] TOL_V = (DW+1)'(TOL);

  // Elaboration-time parameter sanity.
  if (TOL < 0 || TIMEOUT < 1) begin : g_bad_param
    $error("iir_result_checker: TOL must be >= 0 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state;
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_idx;
  logic [AW:0]   r_n;

  logic [AW:0]   w_n_clamp;
  logic [DW-1:0] w_exp;
  logic [DW:0]   w_diff;
  logic [DW:0]   w_abs;
  logic          w_fail;
  logic          w_last;
  logic [AW:0]   w_err_inc;

  assign w_n_clamp = (n_exp > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : n_exp;
  assign w_exp     = r_mem[r_idx];
  // One extra bit so extreme opposite-sign values (e.g. 255 vs -256) never wrap.
  assign w_diff    = {din[DW-1], din} - {w_exp[DW-1], w_exp};
  assign w_abs     = w_diff[DW] ? (~w_diff + 1'b1) : w_diff;
  assign w_fail    = (w_abs > TOL_V);
  assign w_last    = ({1'b0, r_idx} == (r_n - 1'b1));
  assign w_err_inc = (&err_cnt) ? err_cnt : (err_cnt + 1'b1);

  // Expected memory is intentionally not reset; contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (load_en && (r_state != S_RUN)) begin
      r_mem[load_addr] <= load_data;
    end
  end

`ifdef CHK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] r_idle;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_n       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      mismatch  <= 1'b0;
      err_cnt   <= '0;
      first_err <= '0;
      overflow  <= 1'b0;
`ifdef CHK_TIMEOUT_EN
      timeout   <= 1'b0;
      r_idle    <= '0;
`endif
    end else begin
      mismatch <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_n       <= w_n_clamp;
            r_idx     <= '0;
            err_cnt   <= '0;
            first_err <= '0;
            overflow  <= 1'b0;
`ifdef CHK_TIMEOUT_EN
            timeout   <= 1'b0;
            r_idle    <= '0;
`endif
            if (w_n_clamp == '0) begin
              r_state <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= 1'b1;
            end else begin
              r_state <= S_RUN;
              busy    <= 1'b1;
              done    <= 1'b0;
              pass    <= 1'b0;
            end
          end else if ((r_state == S_DONE) && vin) begin
            // Extra sample after the run: flagged, not compared.
            overflow <= 1'b1;
            pass     <= 1'b0;
          end
        end
        S_RUN: begin
          if (vin) begin
            r_idx <= r_idx + 1'b1;
`ifdef CHK_TIMEOUT_EN
            r_idle <= '0;
`endif
            if (w_fail) begin
              mismatch <= 1'b1;
              err_cnt  <= w_err_inc;
              if (err_cnt == '0) first_err <= r_idx;
            end
            if (w_last) begin
              r_state <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              // Verdict includes the result of this final sample.
              pass    <= !w_fail && (err_cnt == '0);
            end
          end
`ifdef CHK_TIMEOUT_EN
          else if (r_idle == TO_LAST) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end else begin
            r_idle <= r_idle + 1'b1;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
